// File: rtl/freq_meter_pkg.sv
// Shared types and default sizes for the frequency meter.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_GATE_CYCLES = 50000000;
    localparam int DEF_CNT_W       = 32;

endpackage

// File: rtl/freq_meter_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// The rise pulse appears three clk cycles after the d_in transition.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_rise;

    // Synchronize d_in, then flag the cycle where the synchronized level goes 0->1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_meta <= d_in;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_rise <= r_sync & ~r_prev;
        end
    end

    assign rise = r_rise;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts rising edges of sig_in over GATE_CYCLES clk cycles.
// Optional macro FREQ_METER_CONTINUOUS_EN: windows repeat back-to-back after
// the first start, with an edge in the DONE cycle credited to the next window.
//
// state | meaning
// IDLE  | waiting for start
// GATE  | counting edges for GATE_CYCLES cycles
// DONE  | one cycle, result registered, valid high
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int               TMR_W    = $clog2(GATE_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACC_MAX  = '1;

    state_t           r_state;
    state_t           w_state_next;
    logic [TMR_W-1:0] r_timer;
    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] w_acc_next;
    logic [CNT_W-1:0] r_count;
    logic             r_acc_ovf;
    logic             w_acc_ovf_next;
    logic             r_ovf;
    logic             w_rise;
    logic             w_clear;
    logic             w_load;
    logic             w_keep_rise;

    sync_edge u_sync_edge (
        .clk  (clk),
        .rst  (rst),
        .d_in (sig_in),
        .rise (w_rise)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus window clear / result load strobes.
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_load       = 1'b0;
        w_keep_rise  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = GATE;
                    w_clear      = 1'b1;
                end
            end
            GATE: begin
                if (r_timer == TMR_LAST) begin
                    w_state_next = DONE;
                    w_load       = 1'b1;
                end
            end
            DONE: begin
`ifdef FREQ_METER_CONTINUOUS_EN
                w_state_next = GATE;
                w_clear      = 1'b1;
                w_keep_rise  = 1'b1;
`else
                w_state_next = IDLE;
`endif
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Saturating increment; the final gate cycle's edge must reach the result too.
    always_comb begin
        w_acc_next     = r_acc;
        w_acc_ovf_next = r_acc_ovf;
        if (w_rise) begin
            if (r_acc == ACC_MAX) begin
                w_acc_ovf_next = 1'b1;
            end else begin
                w_acc_next = r_acc + CNT_W'(1);
            end
        end
    end

    // Gate timer, accumulator and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer   <= '0;
            r_acc     <= '0;
            r_acc_ovf <= 1'b0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_clear) begin
                r_timer   <= '0;
                r_acc     <= CNT_W'(w_keep_rise & w_rise);
                r_acc_ovf <= 1'b0;
            end else if (r_state == GATE) begin
                r_timer   <= r_timer + TMR_W'(1);
                r_acc     <= w_acc_next;
                r_acc_ovf <= w_acc_ovf_next;
            end
            if (w_load) begin
                r_count <= w_acc_next;
                r_ovf   <= w_acc_ovf_next;
            end
        end
    end

    assign busy     = (r_state != IDLE);
    assign valid    = (r_state == DONE);
    assign count    = r_count;
    assign overflow = r_ovf;

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 50000000, gate window length in clk cycles (>=2).
REQ-002 SHALL have parameter CNT_W, default 32, width of the edge count result.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sig_in  input  1  asynchronous signal under measurement, e.g. a divided clock.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a measurement.
REQ-007 SHALL have port busy  output  1  high while a measurement is in progress.
REQ-008 SHALL have port valid  output  1  one-cycle pulse when count is updated.
REQ-009 SHALL have port count  output  CNT_W  rising edges of sig_in counted in the last gate window.
REQ-010 SHALL have port overflow  output  1  set when the last window's edge count exceeded 2^CNT_W-1.

Function
REQ-011 SHALL pass sig_in through a 2-flop synchronizer and then a rising-edge detector producing a one-cycle edge pulse.
- Edge pulse latency: 3 clk cycles after the sig_in transition.
REQ-012 SHALL implement FSM states IDLE, GATE and DONE.
REQ-013 IDLE -> GATE on the clk edge where start=1; the gate timer and edge accumulator clear on that same edge.
REQ-014 SHALL remain in GATE for exactly GATE_CYCLES cycles, then move to DONE.
REQ-015 SHALL add 1 to the accumulator for each edge pulse seen while in GATE; pulses outside GATE are ignored.
REQ-016 The accumulator SHALL saturate at 2^CNT_W-1; a further pulse sets an internal overflow bit and does not wrap.
REQ-017 On entry to DONE:
- count and overflow SHALL load from the accumulator and overflow bit.
- valid SHALL be 1 for that single DONE cycle.
- The state SHALL then return to IDLE.
REQ-018 busy SHALL be 1 in GATE and DONE, and 0 in IDLE.
REQ-019 start SHALL be ignored while busy=1; no queuing, no restart.
REQ-020 count and overflow SHALL hold their values until the next DONE.

Reset
REQ-021 rst=1 SHALL, on the next clk edge, force:
- state=IDLE, busy=0, valid=0, count=0, overflow=0;
- accumulator=0, gate timer=0;
- synchronizer and edge-detector flops=0.
REQ-022 rst asserted during GATE SHALL abort the measurement; no valid pulse is produced and the previous count is cleared.
REQ-023 rst SHALL take priority over start in the same cycle.

Configuration
REQ-024 The macro FREQ_METER_CONTINUOUS_EN SHALL select continuous mode.
- Defined: DONE SHALL go directly to GATE with the timer and accumulator cleared, so measurements repeat back-to-back without start. busy stays 1 after the first start until rst. There is no edge loss between windows: an edge pulse in the DONE cycle counts toward the new window.
- Undefined: single-shot behaviour per REQ-013 to REQ-019.

Structure
REQ-025 SHALL place the FSM state enum (IDLE/GATE/DONE) and the default widths in a shared package freq_meter_pkg.
REQ-026 SHALL implement the synchronizer and edge detector (REQ-011) as a sub-module sync_edge with ports clk, rst, d_in and rise.
REQ-027 The gate timer width SHALL be $clog2(GATE_CYCLES+1).

Verification
REQ-028 Bench SHALL run the following with GATE_CYCLES=100, CNT_W=8 unless stated otherwise.
- sig_in=clk/4 square wave, start pulse -> valid exactly 101 cycles after start; count=25 (+-1 phase); overflow=0.
- sig_in held 0 -> count=0; valid pulses once; busy=1 for 101 cycles then 0.
- CNT_W=4, sig_in=clk/2 -> count=15, overflow=1; count does not wrap.
- Reset at cycle 50 of GATE -> busy=0 on the next cycle; no valid pulse; count=0; a new start then gives a normal result.
- start pulsed again at cycles 10 and 100 of GATE -> ignored; one valid only, at cycle 101.
- With FREQ_METER_CONTINUOUS_EN and sig_in=clk/4 -> a valid pulse every 101 cycles; each count is 25+-1; busy stays 1.
